rv32_mc_ctrl: RTL
=================

// Module: rv32_mc_ctrl
// PURPOSE
//  Multi-cycle control FSM for the RV32I core. It sequences the single shared ALU for PC increment, branch
//  target, address and result use, and drives datapath enables/muxes and the memory request handshake.
//  It decodes opcode/funct3 for legality and emits one alu_ctl per cycle; illegal state is a sticky TRAP.
// PARAMETERS
//  MEM_TIMEOUT    16  max cycles mem_req may wait for mem_ready before TRAP (>=2)
//  ALU_CTL_WIDTH  4   width of alu_ctl, equal to `ALU_CTL_WIDTH
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  opcode        in   7   IR[6:0] (valid from DECODE onward)
//  funct3        in   3   IR[14:12]
//  funct7        in   7   IR[31:25]
//  cmp_true      in   1   ALU result bit0 this cycle (branch compare outcome)
//  mem_ready     in   1   memory completes current request
//  mem_req       out  1   memory request, held until mem_ready
//  mem_we        out  1   1=store, 0=read; valid with mem_req
//  mem_addr_sel  out  1   0=PC, 1=ALUOUT
//  ir_we/oldpc_we/pc_we/rf_we/aluout_we/mdr_we  out 1 each  register write enables
//  pc_src        out  1   0=ALU result, 1=ALUOUT
//  alu_a_sel     out  2   0=RS1, 1=PC, 2=OLDPC
//  alu_b_sel     out  2   0=RS2, 1=IMM, 2=const 4
//  alu_ctl       out  ALU_CTL_WIDTH  ALU op
//  wb_sel        out  2   0=ALUOUT, 1=MDR, 2=PC, 3=IMM
//  instr_done    out  1   one-cycle pulse at the last cycle of each retired instruction
//  trap          out  1   sticky illegal/timeout flag
// BEHAVIOUR
//  - Outputs are Moore-style from state, plus opcode/funct3/cmp_true/mem_ready. While rst=1 all outputs are 0,
//    state<=FETCH, timer<=0, trap<=0. Reset mid-access drops mem_req in the rst cycle, with no enables.
//  - FETCH: mem_req=1, mem_addr_sel=PC. On mem_ready: ir_we, oldpc_we, pc_we (A=PC, B=4, ADD, pc_src=ALU)
//    -> DECODE. Otherwise stay in FETCH.
//  - DECODE (1 cycle): A=OLDPC, B=IMM, ADD, aluout_we (branch/JAL target) -> EXEC.
//    Illegal opcode, branch f3 010/011, load f3 011/110/111, store f3>010 -> TRAP.
//  - EXEC:
//    - OP/OP_IMM: A=RS1, B=RS2/IMM, alu_ctl from decoder, aluout_we -> WB.
//    - LOAD/STORE: A=RS1, B=IMM, ADD, aluout_we -> MEM.
//    - BRANCH: A=RS1, B=RS2, decoder compare. pc_we=cmp_true, pc_src=ALUOUT, instr_done -> FETCH.
//    - JAL: pc_we, pc_src=ALUOUT, rf_we, wb_sel=PC, instr_done -> FETCH.
//    - JALR: A=RS1, B=IMM, ADD, pc_we, pc_src=ALU (datapath clears bit0), rf_we, wb_sel=PC, done -> FETCH.
//    - LUI: rf_we, wb_sel=IMM, done -> FETCH.
//    - AUIPC: A=OLDPC, B=IMM, ADD, aluout_we -> WB.
//  - MEM: mem_req=1, mem_addr_sel=ALUOUT, mem_we=(STORE). On mem_ready: LOAD -> mdr_we, go WB;
//    STORE -> instr_done, go FETCH.
//  - WB: rf_we=1, wb_sel=MDR for LOAD else ALUOUT, instr_done -> FETCH.
//  - TRAP: trap=1, all enables and mem_req 0, held until rst.
//  - Timer: clears on entering FETCH/MEM and increments each cycle with mem_req & !mem_ready.
//    At MEM_TIMEOUT-1 with !mem_ready -> TRAP. A mem_ready in that same cycle wins (normal completion).
//  - mem_ready while mem_req=0 is ignored.
//  - The rf_we write of PC in JAL/JALR samples PC before the same-edge pc_we update (link = PC+4).
//  - Latency (zero-wait memory): ALU/AUIPC 4, LOAD 5, STORE 4, branch/JAL/JALR/LUI 3 cycles.
// STRUCTURE
//  - Package rv32_mc_ctrl_pkg: state enum {FETCH,DECODE,EXEC,MEM,WB,TRAP}, a_sel/b_sel/wb_sel enums.
//    Opcode/funct3 constants come from the shared rv32i defs.
//  - Sub-module: alu_decoder instance supplies alu_ctl for OP/OP_IMM/BRANCH; FSM overrides with ADD elsewhere.
//  - Timeout counter is inline, $clog2(MEM_TIMEOUT) bits.
// TESTING
//  - ADDI x1,x0,5 (0x00500093), zero-wait memory -> FETCH,DECODE,EXEC,WB; rf_we in cycle 4; instr_done once.
//  - BEQ with cmp_true=1 then 0 -> pc_we=1 / pc_we=0 in EXEC; pc_src=ALUOUT; 3 cycles each.
//  - LW with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, mdr_we in ready cycle,
//    then WB wb_sel=MDR.
//  - opcode 0x7F or branch funct3=010 -> TRAP after DECODE; trap stays 1 and no enables for 20 cycles;
//    rst clears it.
//  - mem_ready never asserted in FETCH -> trap=1 after exactly MEM_TIMEOUT=16 cycles of mem_req.
//    mem_ready at cycle 16 -> normal.
//  - rst asserted mid-MEM of a SW -> mem_req=0 in the rst cycle. After release, FETCH with mem_req=1
//    on the next cycle and no stale mem_we.

Source files
------------

// File: rtl/rv32_mc_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle controller:
// FSM states, datapath mux encodings, opcode/funct3 values, ALU op codes
// and the instruction legality check used in DECODE.
package rv32_mc_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    A_RS1   = 2'd0,
    A_PC    = 2'd1,
    A_OLDPC = 2'd2
  } a_sel_e;

  typedef enum logic [1:0] {
    B_RS2  = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2
  } b_sel_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2,
    WB_IMM    = 2'd3
  } wb_sel_e;

  // RV32I base opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct3 values for OP/OP_IMM
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct3 values for BRANCH
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // ALU operation codes; compare ops return their outcome in result bit0
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NE   = 4'd11;
  localparam logic [3:0] ALU_GE   = 4'd12;
  localparam logic [3:0] ALU_GEU  = 4'd13;

  // Legal opcode and funct3 combinations accepted by this controller
  function automatic logic is_legal(input logic [6:0] opc, input logic [2:0] f3);
    logic ok;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM: ok = 1'b1;
      OPC_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
      OPC_LOAD:   ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OPC_STORE:  ok = (f3 <= 3'b010);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv32_mc_ctrl_alu_decoder.sv
// ALU operation decoder: maps opcode/funct3/funct7 to an ALU op for
// register-register, register-immediate and branch-compare instructions.
// Everything else decodes to ADD; the FSM decides when to use this output.
module rv32_mc_ctrl_alu_decoder
  import rv32_mc_ctrl_pkg::*;
#(
  parameter int ALU_CTL_WIDTH = 4
) (
  input  logic [6:0]               i_opcode,
  input  logic [2:0]               i_funct3,
  input  logic [6:0]               i_funct7,
  output logic [ALU_CTL_WIDTH-1:0] o_alu_ctl
);

  logic [3:0] w_op;
  logic       w_alt;
  logic       w_unused_f7;

  // Only funct7[5] selects SUB/SRA; the other bits do not affect the op.
  assign w_alt       = i_funct7[5];
  assign w_unused_f7 = ^{i_funct7[6], i_funct7[4:0]};

  // Operation select from instruction fields
  always_comb begin
    w_op = ALU_ADD;
    case (i_opcode)
      OPC_OP, OPC_OP_IMM: begin
        case (i_funct3)
          F3_ADD:  w_op = (i_opcode == OPC_OP && w_alt) ? ALU_SUB : ALU_ADD;
          F3_SLL:  w_op = ALU_SLL;
          F3_SLT:  w_op = ALU_SLT;
          F3_SLTU: w_op = ALU_SLTU;
          F3_XOR:  w_op = ALU_XOR;
          F3_SR:   w_op = w_alt ? ALU_SRA : ALU_SRL;
          F3_OR:   w_op = ALU_OR;
          F3_AND:  w_op = ALU_AND;
          default: w_op = ALU_ADD;
        endcase
      end
      OPC_BRANCH: begin
        case (i_funct3)
          F3_BEQ:  w_op = ALU_EQ;
          F3_BNE:  w_op = ALU_NE;
          F3_BLT:  w_op = ALU_SLT;
          F3_BGE:  w_op = ALU_GE;
          F3_BLTU: w_op = ALU_SLTU;
          F3_BGEU: w_op = ALU_GEU;
          default: w_op = ALU_ADD;
        endcase
      end
      default: w_op = ALU_ADD;
    endcase
  end

  assign o_alu_ctl = ALU_CTL_WIDTH'(w_op);

endmodule

// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core. Sequences the shared ALU
// through FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and muxes,
// runs the memory request handshake with a wait-cycle timeout, and parks
// in a sticky TRAP state on illegal instructions or memory timeout.
module rv32_mc_ctrl
  import rv32_mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int ALU_CTL_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic                     cmp_true,
  input  logic                     mem_ready,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_addr_sel,
  output logic                     ir_we,
  output logic                     oldpc_we,
  output logic                     pc_we,
  output logic                     rf_we,
  output logic                     aluout_we,
  output logic                     mdr_we,
  output logic                     pc_src,
  output logic [1:0]               alu_a_sel,
  output logic [1:0]               alu_b_sel,
  output logic [ALU_CTL_WIDTH-1:0] alu_ctl,
  output logic [1:0]               wb_sel,
  output logic                     instr_done,
  output logic                     trap
);

  localparam int TW = $clog2(MEM_TIMEOUT);

  state_e                   r_state;
  state_e                   w_next;
  logic [TW-1:0]            r_timer;
  logic                     w_timer_last;
  logic [ALU_CTL_WIDTH-1:0] w_dec_ctl;

  logic                     w_mem_req, w_mem_we, w_mem_addr_sel;
  logic                     w_ir_we, w_oldpc_we, w_pc_we, w_rf_we;
  logic                     w_aluout_we, w_mdr_we, w_pc_src;
  logic                     w_instr_done, w_trap;
  a_sel_e                   w_a_sel;
  b_sel_e                   w_b_sel;
  wb_sel_e                  w_wb_sel;
  logic [ALU_CTL_WIDTH-1:0] w_alu_ctl;

  rv32_mc_ctrl_alu_decoder #(
    .ALU_CTL_WIDTH(ALU_CTL_WIDTH)
  ) u_alu_decoder (
    .i_opcode (opcode),
    .i_funct3 (funct3),
    .i_funct7 (funct7),
    .o_alu_ctl(w_dec_ctl)
  );

  // Final allowed wait cycle: no mem_ready here means the access timed out.
  assign w_timer_last = (r_timer == TW'(MEM_TIMEOUT - 1));

  // Next state and per-state datapath controls
  always_comb begin
    w_next         = r_state;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_ir_we        = 1'b0;
    w_oldpc_we     = 1'b0;
    w_pc_we        = 1'b0;
    w_rf_we        = 1'b0;
    w_aluout_we    = 1'b0;
    w_mdr_we       = 1'b0;
    w_pc_src       = 1'b0;
    w_a_sel        = A_RS1;
    w_b_sel        = B_RS2;
    w_wb_sel       = WB_ALUOUT;
    w_alu_ctl      = ALU_CTL_WIDTH'(ALU_ADD);
    w_instr_done   = 1'b0;
    w_trap         = 1'b0;
    case (r_state)
      FETCH: begin
        w_mem_req = 1'b1;
        w_a_sel   = A_PC;
        w_b_sel   = B_FOUR;
        if (mem_ready) begin
          w_ir_we    = 1'b1;
          w_oldpc_we = 1'b1;
          w_pc_we    = 1'b1;
          w_next     = DECODE;
        end else if (w_timer_last) begin
          w_next = TRAP;
        end
      end
      DECODE: begin
        // Branch/JAL target precomputed into ALUOUT while decoding
        w_a_sel     = A_OLDPC;
        w_b_sel     = B_IMM;
        w_aluout_we = 1'b1;
        w_next      = is_legal(opcode, funct3) ? EXEC : TRAP;
      end
      EXEC: begin
        case (opcode)
          OPC_OP: begin
            w_alu_ctl   = w_dec_ctl;
            w_aluout_we = 1'b1;
            w_next      = WB;
          end
          OPC_OP_IMM: begin
            w_b_sel     = B_IMM;
            w_alu_ctl   = w_dec_ctl;
            w_aluout_we = 1'b1;
            w_next      = WB;
          end
          OPC_LOAD, OPC_STORE: begin
            w_b_sel     = B_IMM;
            w_aluout_we = 1'b1;
            w_next      = MEM;
          end
          OPC_BRANCH: begin
            w_alu_ctl    = w_dec_ctl;
            w_pc_we      = cmp_true;
            w_pc_src     = 1'b1;
            w_instr_done = 1'b1;
            w_next       = FETCH;
          end
          OPC_JAL: begin
            w_pc_we      = 1'b1;
            w_pc_src     = 1'b1;
            w_rf_we      = 1'b1;
            w_wb_sel     = WB_PC;
            w_instr_done = 1'b1;
            w_next       = FETCH;
          end
          OPC_JALR: begin
            // Link value is the PC register as it stands before this edge
            w_b_sel      = B_IMM;
            w_pc_we      = 1'b1;
            w_rf_we      = 1'b1;
            w_wb_sel     = WB_PC;
            w_instr_done = 1'b1;
            w_next       = FETCH;
          end
          OPC_LUI: begin
            w_rf_we      = 1'b1;
            w_wb_sel     = WB_IMM;
            w_instr_done = 1'b1;
            w_next       = FETCH;
          end
          OPC_AUIPC: begin
            w_a_sel     = A_OLDPC;
            w_b_sel     = B_IMM;
            w_aluout_we = 1'b1;
            w_next      = WB;
          end
          default: w_next = TRAP;
        endcase
      end
      MEM: begin
        w_mem_req      = 1'b1;
        w_mem_addr_sel = 1'b1;
        w_mem_we       = (opcode == OPC_STORE);
        if (mem_ready) begin
          if (opcode == OPC_STORE) begin
            w_instr_done = 1'b1;
            w_next       = FETCH;
          end else begin
            w_mdr_we = 1'b1;
            w_next   = WB;
          end
        end else if (w_timer_last) begin
          w_next = TRAP;
        end
      end
      WB: begin
        w_rf_we      = 1'b1;
        w_wb_sel     = (opcode == OPC_LOAD) ? WB_MDR : WB_ALUOUT;
        w_instr_done = 1'b1;
        w_next       = FETCH;
      end
      TRAP: begin
        w_trap = 1'b1;
      end
      default: w_next = TRAP;
    endcase
  end

  // State register; TRAP only leaves through reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Memory wait timer: restarts on every state change, counts unanswered requests
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_next != r_state) begin
      r_timer <= '0;
    end else if (w_mem_req && !mem_ready) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // All outputs forced low during reset, including an in-flight request
  assign mem_req      = w_mem_req & ~rst;
  assign mem_we       = w_mem_we & ~rst;
  assign mem_addr_sel = w_mem_addr_sel & ~rst;
  assign ir_we        = w_ir_we & ~rst;
  assign oldpc_we     = w_oldpc_we & ~rst;
  assign pc_we        = w_pc_we & ~rst;
  assign rf_we        = w_rf_we & ~rst;
  assign aluout_we    = w_aluout_we & ~rst;
  assign mdr_we       = w_mdr_we & ~rst;
  assign pc_src       = w_pc_src & ~rst;
  assign alu_a_sel    = rst ? 2'b00 : w_a_sel;
  assign alu_b_sel    = rst ? 2'b00 : w_b_sel;
  assign wb_sel       = rst ? 2'b00 : w_wb_sel;
  assign alu_ctl      = rst ? '0 : w_alu_ctl;
  assign instr_done   = w_instr_done & ~rst;
  assign trap         = w_trap & ~rst;

endmodule
